// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns single-cycle core load/store requests into a
// held memory request, stalling the core until acknowledge or a bounded timeout.
module dmem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_en,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_err
);

    // state | meaning
    // IDLE  | waiting for a core load/store; captures the access when one appears
    // REQ   | memory request held; waiting for ack or timeout
    // DONE  | single completion cycle, stall released, core inputs ignored
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         CNT_W   = 8;
    localparam logic [7:0] CNT_END = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                req_any;

    assign req_any = i_read_en | i_write_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    // a simultaneous read+write is issued as a store
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    we_d    = i_write_en;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_mem_ack) begin
                    if (!we_q) rdata_d = i_mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_END) begin
                    // counter would reach TIMEOUT this cycle; ack above takes priority
                    err_d = 1'b1;
                    if (!we_q) rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rst gates stall/request immediately since the register reset is synchronous
    assign o_stall     = rst & (((state_q == IDLE) & req_any) | (state_q == REQ));
    assign o_mem_req   = rst & (state_q == REQ);
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: reset, read/write latency, timeout,
// ack-vs-timeout priority, and reset in the middle of a request.
module tb_dmem_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read_en, i_write_en;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] o_rdata;
    logic          o_stall, o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;
    logic          o_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read_en(i_read_en), .i_write_en(i_write_en),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_stall(o_stall),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    // advance one clock and land 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_read_en   = 1'b0;
        i_write_en  = 1'b0;
        i_mem_ack   = 1'b0;
        i_addr      = '0;
        i_wdata     = '0;
        i_mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst       = 1'b0;
        i_read_en = 1'b1;
        i_addr    = 32'h0000_0AAA;
        tick();
        tick();
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", o_stall); end
        n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", o_mem_req); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", o_err); end
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", o_rdata); end
        n_checks++; if ({o_mem_addr, o_mem_wdata, o_mem_we} !== 65'h0) begin n_fail++;
            $display("FAIL reset_capture got addr %h wdata %h we %b exp 0", o_mem_addr, o_mem_wdata, o_mem_we); end
        idle_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read_ack3();
        int stall_cycles;
        stall_cycles = 0;
        i_read_en = 1'b1;
        i_addr    = 32'h0000_0100;
        #1;
        n_checks++; if (o_stall !== 1'b1 || o_mem_req !== 1'b0) begin n_fail++;
            $display("FAIL rd_cycle0 got stall %b req %b exp 1 0", o_stall, o_mem_req); end
        for (int c = 0; c < 4; c++) begin
            if (o_stall === 1'b1) stall_cycles++;
            if (c == 1) begin
                n_checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_we !== 1'b0) begin n_fail++;
                    $display("FAIL rd_req got req %b addr %h we %b exp 1 100 0", o_mem_req, o_mem_addr, o_mem_we); end
            end
            if (c == 3) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        n_checks++; if (stall_cycles != 4) begin n_fail++; $display("FAIL rd_stall_len got %0d exp 4", stall_cycles); end
        n_checks++; if (o_stall !== 1'b0 || o_mem_req !== 1'b0) begin n_fail++;
            $display("FAIL rd_done got stall %b req %b exp 0 0", o_stall, o_mem_req); end
        n_checks++; if (o_rdata !== 32'hCAFE_F00D || o_err !== 1'b0) begin n_fail++;
            $display("FAIL rd_data got %h err %b exp cafef00d 0", o_rdata, o_err); end
        idle_inputs();
        tick();
        n_checks++; if (o_stall !== 1'b0 || o_mem_addr !== 32'h100) begin n_fail++;
            $display("FAIL rd_idle got stall %b addr %h exp 0 100", o_stall, o_mem_addr); end
    endtask

    task automatic test_write_ack1();
        i_write_en = 1'b1;
        i_addr     = 32'h0000_0040;
        i_wdata    = 32'h1234_5678;
        tick();
        n_checks++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_wdata !== 32'h1234_5678 || o_mem_addr !== 32'h40) begin n_fail++;
            $display("FAIL wr_req got req %b we %b wdata %h addr %h exp 1 1 12345678 40", o_mem_req, o_mem_we, o_mem_wdata, o_mem_addr); end
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h5555_AAAA;
        tick();
        i_mem_ack = 1'b0;
        n_checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin n_fail++;
            $display("FAIL wr_done got req %b stall %b exp 0 0", o_mem_req, o_stall); end
        n_checks++; if (o_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_rdata_kept got %h exp cafef00d", o_rdata); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        i_read_en = 1'b1;
        i_addr    = 32'h0000_0200;
        tick();
        n = 0;
        while (o_mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n != TO) begin n_fail++; $display("FAIL to_req_cycles got %0d exp %0d", n, TO); end
        n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_stall !== 1'b0) begin n_fail++;
            $display("FAIL to_done got err %b rdata %h stall %b exp 1 0 0", o_err, o_rdata, o_stall); end
        idle_inputs();
        tick();
        i_read_en = 1'b1;
        i_addr    = 32'h0000_0300;
        tick();
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hA5A5_0001;
        tick();
        idle_inputs();
        n_checks++; if (o_rdata !== 32'hA5A5_0001 || o_err !== 1'b1 || o_stall !== 1'b0) begin n_fail++;
            $display("FAIL to_next_read got rdata %h err %b stall %b exp a5a50001 1 0", o_rdata, o_err, o_stall); end
        tick();
    endtask

    task automatic test_reset_mid_req();
        i_read_en = 1'b1;
        i_addr    = 32'h0000_0500;
        i_wdata   = 32'h0BAD_0BAD;
        tick();
        tick();
        n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_before got %b exp 1", o_mem_req); end
        rst = 1'b0;
        tick();
        n_checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h0) begin n_fail++;
            $display("FAIL mid_rst_out got req %b stall %b err %b rdata %h exp 0 0 0 0", o_mem_req, o_stall, o_err, o_rdata); end
        n_checks++; if ({o_mem_addr, o_mem_wdata, o_mem_we} !== 65'h0) begin n_fail++;
            $display("FAIL mid_rst_capture got addr %h wdata %h we %b exp 0", o_mem_addr, o_mem_wdata, o_mem_we); end
        rst = 1'b1;
        idle_inputs();
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hFFFF_FFFF;
        tick();
        i_mem_ack = 1'b0;
        tick();
        n_checks++; if (o_rdata !== 32'h0 || o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_err !== 1'b0) begin n_fail++;
            $display("FAIL stray_ack got rdata %h req %b stall %b err %b exp 0 0 0 0", o_rdata, o_mem_req, o_stall, o_err); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        i_read_en  = 1'b1;
        i_write_en = 1'b1;
        i_addr     = 32'h0000_0080;
        i_wdata    = 32'hDEAD_BEEF;
        tick();
        n_checks++; if (o_mem_we !== 1'b1 || o_mem_wdata !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL sim_store got we %b wdata %h exp 1 deadbeef", o_mem_we, o_mem_wdata); end
        for (int c = 1; c < TO; c++) tick();
        n_checks++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL sim_last_req got %b exp 1", o_mem_req); end
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h1111_1111;
        tick();
        idle_inputs();
        n_checks++; if (o_err !== 1'b0 || o_rdata !== 32'h0 || o_stall !== 1'b0 || o_mem_req !== 1'b0) begin n_fail++;
            $display("FAIL sim_ack_wins got err %b rdata %h stall %b req %b exp 0 0 0 0", o_err, o_rdata, o_stall, o_mem_req); end
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_read_ack3();
        test_write_ack1();
        test_timeout();
        test_reset_mid_req();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles to wait for memory acknowledge (legal range 1-255).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port i_read_en, input, 1, core load request.
REQ-007 SHALL have port i_write_en, input, 1, core store request.
REQ-008 SHALL have port i_addr, input, ADDR_W, core access address.
REQ-009 SHALL have port i_wdata, input, DATA_W, core store data.
REQ-010 SHALL have port o_rdata, output, DATA_W, load data returned to core.
REQ-011 SHALL have port o_stall, output, 1, hold request to core's pipeline stall input.
REQ-012 SHALL have port o_mem_req, output, 1, memory-side request valid.
REQ-013 SHALL have port o_mem_we, output, 1, memory-side write enable (1 = store).
REQ-014 SHALL have port o_mem_addr, output, ADDR_W, memory-side address.
REQ-015 SHALL have port o_mem_wdata, output, DATA_W, memory-side store data.
REQ-016 SHALL have port i_mem_ack, input, 1, memory acknowledge (one cycle pulse).
REQ-017 SHALL have port i_mem_rdata, input, DATA_W, memory load data, valid with i_mem_ack.
REQ-018 SHALL have port o_err, output, 1, sticky timeout error flag.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, DONE.
REQ-020 IDLE: on i_read_en or i_write_en, SHALL capture i_addr, i_wdata, and we = i_write_en, then move to REQ next cycle.
REQ-021 If i_read_en and i_write_en are both high, SHALL treat the access as a store.
REQ-022 o_stall SHALL be combinational: high in IDLE when a request is present, and high throughout REQ; low in DONE.
REQ-023 In REQ, o_mem_req SHALL be 1 and o_mem_addr/o_mem_we/o_mem_wdata SHALL hold the captured values, stable until ack or timeout.
REQ-024 In REQ, i_mem_ack=1 SHALL load o_rdata with i_mem_rdata (reads only; stores leave o_rdata unchanged) and move to DONE.
REQ-025 Latency: request sampled at cycle 0, o_mem_req high from cycle 1; ack at cycle k gives DONE at cycle k+1 with o_stall low.
REQ-026 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-027 When the counter reaches TIMEOUT without ack, SHALL set o_err, force o_rdata to 0 on a read, and move to DONE.
REQ-028 Ack and timeout in the same cycle: ack SHALL win; o_err SHALL not be set.
REQ-029 DONE SHALL last exactly one cycle, ignore core request inputs (the core is still presenting the completing access), then return to IDLE.
REQ-030 i_mem_ack outside REQ SHALL be ignored.
REQ-031 o_err SHALL be sticky until reset; the controller SHALL keep serving requests while o_err=1.
REQ-032 Outside REQ, o_mem_req SHALL be 0; o_mem_addr, o_mem_we and o_mem_wdata SHALL hold their last values.

Reset
REQ-033 rst=0 at a clock edge SHALL force IDLE, counter 0, o_err 0, o_rdata 0, and captured address, data and we 0.
REQ-034 Reset during REQ SHALL drop o_mem_req in the cycle following the edge, with no DONE cycle.
REQ-035 While rst=0, o_stall and o_mem_req SHALL be 0 regardless of inputs.

Verification
REQ-036 Read, ack after 3 cycles: i_read_en, addr 0x100, i_mem_rdata 0xCAFEF00D -> o_stall high 4 cycles, then o_rdata=0xCAFEF00D, o_stall low, o_err 0.
REQ-037 Write, ack on the first REQ cycle: addr 0x40, wdata 0x12345678 -> o_mem_we=1, o_mem_wdata=0x12345678 for 1 cycle, o_rdata unchanged.
REQ-038 Timeout: read with no ack, TIMEOUT=16 -> DONE after 16 REQ cycles, o_err=1, o_rdata=0; the next read acked normally completes with o_err still 1.
REQ-039 Simultaneous read and write requests -> store issued (o_mem_we=1); ack on cycle counter=TIMEOUT -> no error.
REQ-040 Reset mid-REQ: assert rst=0 at REQ cycle 2 -> o_mem_req 0 and all outputs at reset values the next cycle; a stray i_mem_ack afterwards is ignored.
